fp_adder_rr_scheduler: RTL
==========================

// Module: fp_adder_rr_scheduler
// PURPOSE
//  Shares one fully pipelined floating_point_adder between N_REQ requesters.
//  - Round-robin arbitration over valid/ready request channels.
//  - Drives the adder's operand and arg_vld inputs.
//  - Tracks a requester tag down a LATENCY-deep pipe and returns each sum to the requester that issued it.
//  - Sits between the compute clients and the FPU adder instance.
// PARAMETERS
//  N_REQ    4   number of requesters (2..16)
//  LATENCY  6   adder cycles from arg_vld cycle to result cycle (matches adder STAGES)
//  ID_W     $clog2(N_REQ)  derived; tag width, not overridden
// PORTS
//  clk            in   1         clock, all logic on posedge
//  rst            in   1         synchronous reset, active-high
//  req_vld        in   N_REQ     requester i has an operand pair
//  req_a          in   32*N_REQ  operand A of requester i at [32*i +: 32] {sign,exp[7:0],mant[22:0]}
//  req_b          in   32*N_REQ  operand B, same packing
//  req_rdy        out  N_REQ     one-hot grant, combinational
//  fpu_a          out  32        operand A to adder
//  fpu_b          out  32        operand B to adder
//  fpu_arg_vld    out  1         operands valid this cycle
//  fpu_result     in   32        adder result
//  fpu_res_state  in   2         adder state (00 OK, 01 NAN, 10 INF, 11 NUL)
//  rsp_vld        out  N_REQ     one-hot: response belongs to requester i
//  rsp_result     out  32        returned sum
//  rsp_state      out  2         returned state
//  busy           out  1         at least one operation in flight
// BEHAVIOUR
//  - Reset values:
//    - Outputs: req_rdy, fpu_arg_vld, rsp_vld, busy = 0; fpu_a, fpu_b, rsp_result, rsp_state = 0.
//    - Internal: RR pointer = 0; every tag-pipe entry invalid.
//  - Handshake:
//    - A transfer occurs in cycle k when req_vld[i] & req_rdy[i].
//    - A requester holds req_vld, req_a and req_b stable until it is granted.
//    - req_rdy is never asserted while rst is high.
//  - Arbitration:
//    - At most one grant per cycle.
//    - Search order is ptr, ptr+1, ... wrapping modulo N_REQ.
//    - After a grant to g: ptr <= (g+1) mod N_REQ.
//    - With no request, ptr holds.
//  - Issue:
//    - fpu_a, fpu_b and fpu_arg_vld are registered.
//    - Transfer at k gives fpu_arg_vld = 1 at k+1 with the granted operands.
//    - fpu_a and fpu_b hold their last values while fpu_arg_vld = 0.
//    - Throughput is one op per cycle; there is no back-pressure from the adder.
//  - Tag pipe:
//    - A {valid, id[ID_W-1:0]} shift register of LATENCY stages, loaded in step with fpu_arg_vld.
//    - Its tail aligns with fpu_result at cycle k+1+LATENCY.
//  - Return:
//    - rsp_vld, rsp_result and rsp_state are registered from the tail.
//    - rsp_vld = onehot(id) at k+2+LATENCY; total latency is LATENCY+2.
//    - rsp_vld = 0 when the tail is invalid.
//    - fpu outputs are ignored when the tail is invalid.
//    - Responses are returned in issue order.
//    - Responses cannot be stalled; requesters must accept them.
//  - busy = OR of the issue-stage valid and all tag-pipe valids.
//    - For a single op: busy is high from k+1 to k+1+LATENCY and low at k+2+LATENCY.
//  - Simultaneous issue and return in one cycle are both handled; the pipe shifts every cycle.
//  - Reset mid-operation:
//    - All in-flight tags are discarded; they produce no rsp_vld.
//    - ptr returns to 0; busy is 0 the cycle after rst rises.
//  - rsp_state passes fpu_res_state through unmodified.
// TESTING
//  1. Single op: req_vld=0010, a=0x3F800000, b=0x40000000 at k.
//     -> req_rdy=0010 at k; fpu_arg_vld=1 at k+1.
//     -> rsp_vld=0010, rsp_result=0x40400000 at k+8.
//  2. All four req_vld held high for 8 cycles.
//     -> grants 0,1,2,3,0,1,2,3 back-to-back.
//     -> 8 consecutive rsp_vld with matching one-hot ids and sums.
//  3. Fairness: grant to 2, then req_vld=1001 -> grant 3, then grant 0.
//  4. Reset mid-flight: rst high 2 cycles after 3 issues.
//     -> no rsp_vld afterwards, busy=0, next grant starts at requester 0.
//  5. Special operand: a=0x7F800000, b=0x3F800000 from requester 3.
//     -> rsp_vld=1000 with rsp_state=2'b10 forwarded from the adder.
//  6. Idle gaps: issue, 3 idle cycles, issue.
//     -> rsp_vld low between the two responses; busy falls exactly at the last rsp_vld cycle.

Source files
------------

// File: rtl/fp_adder_rr_scheduler.sv
// ---------------------------------------------------------------------------
// fp_adder_rr_scheduler
//
// Purpose:
//   Lets N_REQ compute clients share one fully pipelined floating-point adder.
//   A round-robin arbiter grants one valid/ready request per cycle. The granted
//   operands are registered onto the adder inputs. The requester id travels
//   down a LATENCY-deep tag pipe alongside the adder, so each sum is returned
//   to the requester that issued it.
//
// Ports:
//   i_clk            clock, all logic on the rising edge
//   i_rst            synchronous reset, active high
//   i_req_vld        per-requester operand pair valid
//   i_req_a/i_req_b  packed operands, requester i at [32*i +: 32]
//   o_req_rdy        one-hot combinational grant
//   o_fpu_a/o_fpu_b  registered operands to the adder
//   o_fpu_arg_vld    registered operand valid to the adder
//   i_fpu_result     adder result (valid LATENCY cycles after arg_vld)
//   i_fpu_res_state  adder status (00 OK, 01 NAN, 10 INF, 11 NUL)
//   o_rsp_vld        one-hot owner of the returned result
//   o_rsp_result     returned sum
//   o_rsp_state      returned adder status, passed through unmodified
//   o_busy           at least one operation in flight
// ---------------------------------------------------------------------------
module fp_adder_rr_scheduler #(
    parameter  int N_REQ   = 4,
    parameter  int LATENCY = 6,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_REQ-1:0]    i_req_vld,
    input  logic [32*N_REQ-1:0] i_req_a,
    input  logic [32*N_REQ-1:0] i_req_b,
    output logic [N_REQ-1:0]    o_req_rdy,
    output logic [31:0]         o_fpu_a,
    output logic [31:0]         o_fpu_b,
    output logic                o_fpu_arg_vld,
    input  logic [31:0]         i_fpu_result,
    input  logic [1:0]          i_fpu_res_state,
    output logic [N_REQ-1:0]    o_rsp_vld,
    output logic [31:0]         o_rsp_result,
    output logic [1:0]          o_rsp_state,
    output logic                o_busy
);

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [31:0]     w_req_a [N_REQ];
    logic [31:0]     w_req_b [N_REQ];

    logic [ID_W-1:0] r_ptr;
    logic            w_gnt_any;
    logic [ID_W-1:0] w_gnt_id;
    logic [31:0]     w_gnt_a;
    logic [31:0]     w_gnt_b;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    logic            r_arg_vld;
    logic [ID_W-1:0] r_iss_id;
    logic [31:0]     r_fpu_a;
    logic [31:0]     r_fpu_b;

    logic            r_tag_vld [LATENCY];
    logic [ID_W-1:0] r_tag_id  [LATENCY];

    logic [N_REQ-1:0] r_rsp_vld;
    logic [31:0]      r_rsp_result;
    logic [1:0]       r_rsp_state;
    logic             w_busy;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_req_a[gi] = i_req_a[32*gi +: 32];
        assign w_req_b[gi] = i_req_b[32*gi +: 32];
    end

    // Round-robin search starting at r_ptr; the index wraps by a single
    // conditional subtract since ptr + offset never exceeds 2*N_REQ-2.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_gnt_a   = '0;
        w_gnt_b   = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(off);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!w_gnt_any && i_req_vld[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_idx;
                w_gnt_a   = w_req_a[w_idx];
                w_gnt_b   = w_req_b[w_idx];
            end
        end
        // No grant may be seen by a requester while the block is in reset.
        if (i_rst) begin
            w_gnt_any = 1'b0;
        end
    end

    assign o_req_rdy = w_gnt_any ? (ONE_HOT0 << w_gnt_id) : '0;

    // Issue stage: operands hold their last value when nothing is granted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr     <= '0;
            r_arg_vld <= 1'b0;
            r_iss_id  <= '0;
            r_fpu_a   <= '0;
            r_fpu_b   <= '0;
        end else begin
            r_arg_vld <= w_gnt_any;
            if (w_gnt_any) begin
                r_iss_id <= w_gnt_id;
                r_fpu_a  <= w_gnt_a;
                r_fpu_b  <= w_gnt_b;
                r_ptr    <= (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
            end
        end
    end

    // Tag pipe shifts every cycle; stage 0 follows the issue stage so the
    // tail lines up with the adder result of the same operation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < LATENCY; j++) begin
                r_tag_vld[j] <= 1'b0;
                r_tag_id[j]  <= '0;
            end
        end else begin
            r_tag_vld[0] <= r_arg_vld;
            r_tag_id[0]  <= r_iss_id;
            for (int j = 1; j < LATENCY; j++) begin
                r_tag_vld[j] <= r_tag_vld[j-1];
                r_tag_id[j]  <= r_tag_id[j-1];
            end
        end
    end

    // Return stage: adder outputs are only captured for a valid tail.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_vld    <= '0;
            r_rsp_result <= '0;
            r_rsp_state  <= '0;
        end else begin
            r_rsp_vld <= r_tag_vld[LATENCY-1] ? (ONE_HOT0 << r_tag_id[LATENCY-1]) : '0;
            if (r_tag_vld[LATENCY-1]) begin
                r_rsp_result <= i_fpu_result;
                r_rsp_state  <= i_fpu_res_state;
            end
        end
    end

    always_comb begin
        w_busy = r_arg_vld;
        for (int j = 0; j < LATENCY; j++) begin
            w_busy = w_busy | r_tag_vld[j];
        end
    end

    assign o_fpu_a       = r_fpu_a;
    assign o_fpu_b       = r_fpu_b;
    assign o_fpu_arg_vld = r_arg_vld;
    assign o_rsp_vld     = r_rsp_vld;
    assign o_rsp_result  = r_rsp_result;
    assign o_rsp_state   = r_rsp_state;
    assign o_busy        = w_busy;

endmodule
